// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl -- sequencer for the FIR engine.
//
// Owns the ap_start/ap_done/ap_idle handshake. It also generates the
// shift-data RAM circular-buffer addressing, the tap-RAM read addressing,
// the MAC clear/enable strobes, and the AXI-Stream input/output handshakes.
//
// Ports
//   axis_clk, axis_rst_n       clock, async active-low reset
//   cfg_start/cfg_len          start pulse and block length (latched on accept)
//   cfg_done_clr               clears sticky ap_done
//   ap_start/ap_idle/ap_done   status back to the config block
//   cfg_lock                   high while busy (tap writes must be rejected)
//   err_tlast                  sticky: ss_tlast disagreed with the sample count
//   ss_t*                      input sample stream (data goes straight to data RAM)
//   sm_t*                      output stream (data is the datapath accumulator)
//   data_en/we/wdata_sel/data_a  data-RAM control
//   tap_en/tap_a               tap-RAM read control
//   mac_clr/mac_en             accumulator control
module fir_seq_ctrl #(
    parameter int NUM_TAP = 11,
    parameter int PTR_W   = 4,
    parameter int LEN_W   = 32
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_done_clr,
    output logic             ap_start,
    output logic             ap_idle,
    output logic             ap_done,
    output logic             cfg_lock,
    output logic             err_tlast,
    input  logic             ss_tvalid,
    input  logic             ss_tlast,
    output logic             ss_tready,
    output logic             sm_tvalid,
    input  logic             sm_tready,
    output logic             sm_tlast,
    output logic             data_en,
    output logic             data_we,
    output logic             wdata_sel,
    output logic [PTR_W-1:0] data_a,
    output logic             tap_en,
    output logic [PTR_W-1:0] tap_a,
    output logic             mac_clr,
    output logic             mac_en
);

    // idx counts to NUM_TAP inclusive in MAC, so it gets one extra bit.
    localparam int IW = PTR_W + 1;
    localparam logic [IW-1:0]    NT_I     = IW'(NUM_TAP);
    localparam logic [IW-1:0]    NT_LAST  = IW'(NUM_TAP - 1);
    localparam logic [PTR_W-1:0] HEAD_TOP = PTR_W'(NUM_TAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_X, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    mac_addr;

    logic start_ok, is_last, x_hs, y_hs;

    assign start_ok = cfg_start && (state == S_IDLE || state == S_DONE);
    assign is_last  = (count == len_r - LEN_W'(1));
    assign x_hs     = (state == S_WAIT_X) && ss_tvalid;
    assign y_hs     = (state == S_OUT) && sm_tready;

    // Newest sample sits at head; tap j pairs with the sample j steps older.
    always_comb begin
        if ({1'b0, head} >= idx) mac_addr = {1'b0, head} - idx;
        else                     mac_addr = {1'b0, head} + NT_I - idx;
    end

    // State register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (cfg_start) state_nxt = (cfg_len == '0) ? S_DONE : S_INIT;
            S_INIT:         if (idx == NT_LAST) state_nxt = S_WAIT_X;
            S_WAIT_X:       if (ss_tvalid) state_nxt = S_MAC;
            S_MAC:          if (idx == NT_I) state_nxt = S_OUT;
            S_OUT:          if (sm_tready) state_nxt = is_last ? S_DONE : S_WAIT_X;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Counters and sticky status
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_r     <= '0;
            count     <= '0;
            head      <= '0;
            idx       <= '0;
            ap_start  <= 1'b0;
            ap_done   <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            if (state_nxt != state)                    idx <= '0;
            else if (state == S_INIT || state == S_MAC) idx <= idx + IW'(1);

            if (start_ok && cfg_len != '0) begin
                len_r     <= cfg_len;
                count     <= '0;
                head      <= '0;
                ap_start  <= 1'b1;
                err_tlast <= 1'b0;
            end

            if (x_hs) begin
                ap_start <= 1'b0;
                if (ss_tlast != is_last) err_tlast <= 1'b1;
            end

            if (y_hs) begin
                head  <= (head == HEAD_TOP) ? '0 : head + PTR_W'(1);
                count <= count + LEN_W'(1);
            end

            // Entering DONE beats a simultaneous clear.
            if ((start_ok && cfg_len == '0) || (y_hs && is_last)) ap_done <= 1'b1;
            else if (start_ok || cfg_done_clr)                    ap_done <= 1'b0;
        end
    end

    // Outputs
    always_comb begin
        ap_idle   = (state == S_IDLE) || (state == S_DONE);
        cfg_lock  = ~ap_idle;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        data_en   = 1'b0;
        data_we   = 1'b0;
        wdata_sel = 1'b0;
        data_a    = '0;
        tap_en    = 1'b0;
        tap_a     = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            S_INIT: begin
                data_en = 1'b1;
                data_we = 1'b1;
                data_a  = idx[PTR_W-1:0];
            end
            S_WAIT_X: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_en   = 1'b1;
                    data_we   = 1'b1;
                    wdata_sel = 1'b1;
                    data_a    = head;
                    mac_clr   = 1'b1;
                end
            end
            S_MAC: begin
                if (idx < NT_I) begin
                    tap_en  = 1'b1;
                    data_en = 1'b1;
                    tap_a   = idx[PTR_W-1:0];
                    data_a  = mac_addr[PTR_W-1:0];
                end
                // RAM read data lags the address by one cycle.
                mac_en = (idx != '0);
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = is_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;
    localparam int NT = 11;
    localparam int PW = 4;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0, cfg_done_clr = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          ap_start, ap_idle, ap_done, cfg_lock, err_tlast;
    logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
    logic          sm_tvalid, sm_tready = 1'b0, sm_tlast;
    logic          data_en, data_we, wdata_sel, tap_en, mac_clr, mac_en;
    logic [PW-1:0] data_a, tap_a;

    always #5 clk = ~clk;

    fir_seq_ctrl #(.NUM_TAP(NT), .PTR_W(PW), .LEN_W(LW)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_done_clr(cfg_done_clr),
        .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .cfg_lock(cfg_lock), .err_tlast(err_tlast),
        .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
        .data_en(data_en), .data_we(data_we), .wdata_sel(wdata_sel), .data_a(data_a),
        .tap_en(tap_en), .tap_a(tap_a), .mac_clr(mac_clr), .mac_en(mac_en)
    );

    int total = 0, bad = 0;

    // Datapath stand-in: two 1-cycle-latency RAMs and an accumulator.
    int taps [NT];
    int dram [16];
    int x_in = 0, data_q = 0, tap_q = 0, acc = 0;
    always @(posedge clk) begin
        if (data_en) begin
            if (data_we) dram[data_a] <= wdata_sel ? x_in : 0;
            data_q <= dram[data_a];
        end
        if (tap_en) tap_q <= taps[tap_a];
        if (mac_clr)     acc <= 0;
        else if (mac_en) acc <= acc + tap_q * data_q;
    end

    logic [PW-1:0] trace_q[$];
    bit trace_on = 0;
    always @(posedge clk) if (trace_on && tap_en) trace_q.push_back(data_a);

    // Invariants checked every cycle out of reset.
    always @(negedge clk) if (rst_n) begin
        total++;
        if ((ss_tready && sm_tvalid) || (cfg_lock !== ~ap_idle)) begin
            bad++;
            $display("FAIL invariant: tready=%b tvalid=%b lock=%b idle=%b", ss_tready, sm_tvalid, cfg_lock, ap_idle);
        end
    end

    // Reference: direct-form convolution over the block, zero history.
    int xq[$];
    int yq[$];
    bit lq[$];
    function automatic int golden(input int n);
        int s = 0;
        for (int k = 0; k < NT; k++) if (n - k >= 0) s += taps[k] * xq[n - k];
        return s;
    endfunction

    task automatic rand_taps();
        for (int k = 0; k < NT; k++) taps[k] = int'($urandom_range(0, 2000)) - 1000;
    endtask

    task automatic rand_x(input int n);
        xq.delete();
        for (int i = 0; i < n; i++) xq.push_back(int'($urandom_range(0, 2000)) - 1000);
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        cfg_len = len; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_x(input int d, input bit last, output bit ok);
        int n = 0;
        ok = 0;
        @(negedge clk);
        while (!ss_tready && n < 200) begin @(negedge clk); n++; end
        if (ss_tready) begin
            x_in = d; ss_tvalid = 1'b1; ss_tlast = last;
            @(posedge clk); #1;
            ss_tvalid = 1'b0; ss_tlast = 1'b0; ok = 1;
        end
    endtask

    task automatic recv_y(input int hold, output int y, output bit last, output bit ok);
        int n = 0;
        ok = 0; y = 0; last = 0;
        @(negedge clk);
        while (!sm_tvalid && n < 200) begin @(negedge clk); n++; end
        if (sm_tvalid) begin
            repeat (hold) @(negedge clk);
            y = acc; last = sm_tlast;
            sm_tready = 1'b1;
            @(posedge clk); #1;
            sm_tready = 1'b0; ok = 1;
        end
    endtask

    // Streams xq[first..] with tlast on the final entry, appends results to yq/lq.
    task automatic run_samples(input int first, input int maxhold, output bit ok);
        bit o1, o2, l;
        int y;
        ok = 1;
        for (int i = first; i < xq.size(); i++) begin
            send_x(xq[i], i == xq.size() - 1, o1);
            recv_y(int'($urandom_range(0, maxhold)), y, l, o2);
            yq.push_back(y); lq.push_back(l);
            if (!(o1 && o2)) begin ok = 0; break; end
        end
    endtask

    task automatic check_block(input string name, input bit ok);
        total++;
        if (!ok || yq.size() != xq.size()) begin
            bad++;
            $display("FAIL %s timeout: got %0d outputs, need %0d", name, yq.size(), xq.size());
            return;
        end
        for (int i = 0; i < xq.size(); i++) begin
            total++;
            if (yq[i] !== golden(i) || lq[i] !== (i == xq.size() - 1)) begin
                bad++;
                $display("FAIL %s y[%0d]: got %0d last=%b, need %0d last=%b",
                         name, i, yq[i], lq[i], golden(i), i == xq.size() - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            total++;
            if ({ap_idle, ss_tready, sm_tvalid, cfg_lock, ap_done, ap_start, err_tlast, data_we} !== 8'b1000_0000) begin
                bad++;
                $display("FAIL reset cyc%0d: idle,rdy,vld,lock,done,start,err,we=%b need 10000000", c,
                         {ap_idle, ss_tready, sm_tvalid, cfg_lock, ap_done, ap_start, err_tlast, data_we});
            end
        end
    endtask

    task automatic test_init_impulse();
        bit ok, l;
        int y;
        for (int k = 0; k < NT; k++) taps[k] = k + 1;
        do_start(3);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if (c <= 11) begin
                if ({data_en, data_we, wdata_sel, ss_tready, ap_start} !== 5'b11001 || data_a !== PW'(c - 1)) begin
                    bad++;
                    $display("FAIL init cyc%0d: en,we,sel,rdy,start=%b a=%0d need 11001 a=%0d",
                             c, {data_en, data_we, wdata_sel, ss_tready, ap_start}, data_a, c - 1);
                end
            end else if ({ss_tready, data_we, ap_start, cfg_lock} !== 4'b1011) begin
                bad++;
                $display("FAIL init ready cyc12: rdy,we,start,lock=%b need 1011", {ss_tready, data_we, ap_start, cfg_lock});
            end
        end
        send_x(1, 0, ok);
        total++;
        if (!ok || ap_start !== 1'b0) begin bad++; $display("FAIL ap_start fall: ok=%b start=%b need 0", ok, ap_start); end
        recv_y(0, y, l, ok);
        total++;
        if (!ok || y !== 1 || l !== 1'b0) begin bad++; $display("FAIL impulse y0: got %0d last=%b need 1 0", y, l); end
        send_x(0, 0, ok);
        recv_y(2, y, l, ok);
        total++;
        if (!ok || y !== 2 || l !== 1'b0) begin bad++; $display("FAIL impulse y1: got %0d last=%b need 2 0", y, l); end
        send_x(0, 1, ok);
        recv_y(1, y, l, ok);
        total++;
        if (!ok || y !== 3 || l !== 1'b1) begin bad++; $display("FAIL impulse y2: got %0d last=%b need 3 1", y, l); end
        total++;
        if ({ap_done, ap_idle, err_tlast} !== 3'b110) begin
            bad++; $display("FAIL impulse done: done,idle,err=%b need 110", {ap_done, ap_idle, err_tlast});
        end
    endtask

    task automatic test_wrap();
        bit ok, o1, o2, l;
        int y;
        rand_taps(); rand_x(13);
        yq.delete(); lq.delete();
        do_start(13);
        ok = 1;
        for (int i = 0; i < 13; i++) begin
            if (i == 11) begin trace_q.delete(); trace_on = 1; end
            send_x(xq[i], i == 12, o1);
            recv_y(int'($urandom_range(0, 3)), y, l, o2);
            trace_on = 0;
            yq.push_back(y); lq.push_back(l);
            if (!(o1 && o2)) begin ok = 0; break; end
        end
        check_block("wrap", ok);
        total++;
        if (trace_q.size() != NT) begin
            bad++; $display("FAIL wrap trace size: got %0d need %0d", trace_q.size(), NT);
        end else begin
            for (int k = 0; k < NT; k++) begin
                total++;
                if (trace_q[k] !== PW'((NT - k) % NT)) begin
                    bad++; $display("FAIL wrap data_a[%0d]: got %0d need %0d", k, trace_q[k], (NT - k) % NT);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, l, tl;
        int y, n;
        rand_taps(); rand_x(2);
        yq.delete(); lq.delete();
        do_start(2);
        send_x(xq[0], 0, ok);
        n = 0;
        @(negedge clk);
        while (!sm_tvalid && n < 200) begin @(negedge clk); n++; end
        y = acc; tl = sm_tlast;
        total++;
        if (!sm_tvalid || tl !== 1'b0) begin bad++; $display("FAIL bp first: vld=%b last=%b need 1 0", sm_tvalid, tl); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ({sm_tvalid, sm_tlast, ss_tready} !== {1'b1, tl, 1'b0} || acc !== y) begin
                bad++; $display("FAIL bp hold cyc%0d: vld,last,rdy=%b acc=%0d need %b acc=%0d",
                                c, {sm_tvalid, sm_tlast, ss_tready}, acc, {1'b1, tl, 1'b0}, y);
            end
        end
        sm_tready = 1'b1;
        @(posedge clk); #1;
        sm_tready = 1'b0;
        yq.push_back(y); lq.push_back(tl);
        run_samples(1, 0, ok);
        check_block("backpressure", ok);
    endtask

    task automatic test_reset_mid();
        bit ok, l;
        int y;
        rand_taps(); rand_x(3);
        do_start(3);
        send_x(xq[0], 0, ok);
        recv_y(0, y, l, ok);
        send_x(xq[1], 0, ok);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ap_idle, ap_start, ss_tready, sm_tvalid, tap_en, mac_en, cfg_lock} !== 7'b1000000) begin
            bad++; $display("FAIL async reset: idle,start,rdy,vld,tap,mac,lock=%b need 1000000",
                            {ap_idle, ap_start, ss_tready, sm_tvalid, tap_en, mac_en, cfg_lock});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_x(2);
        yq.delete(); lq.delete();
        do_start(2);
        run_samples(0, 2, ok);
        check_block("post-reset", ok);
    endtask

    task automatic test_start_ignored();
        bit ok, l;
        int y;
        rand_taps(); rand_x(3);
        yq.delete(); lq.delete();
        do_start(3);
        send_x(xq[0], 0, ok);
        do_start(1);
        total++;
        if ({ap_start, cfg_lock, ap_done} !== 3'b010) begin
            bad++; $display("FAIL start ignored: start,lock,done=%b need 010", {ap_start, cfg_lock, ap_done});
        end
        recv_y(1, y, l, ok);
        yq.push_back(y); lq.push_back(l);
        run_samples(1, 1, ok);
        check_block("start-ignored", ok);
        total++;
        if (ap_done !== 1'b1) begin bad++; $display("FAIL start-ignored done: got %b need 1", ap_done); end
    endtask

    task automatic test_done_len0();
        int we_seen = 0;
        @(negedge clk);
        cfg_done_clr = 1'b1;
        @(posedge clk); #1;
        cfg_done_clr = 1'b0;
        total++;
        if ({ap_done, ap_idle} !== 2'b01) begin bad++; $display("FAIL done clr: done,idle=%b need 01", {ap_done, ap_idle}); end
        do_start(0);
        total++;
        if ({ap_done, ap_idle, ap_start} !== 3'b110) begin
            bad++; $display("FAIL len0: done,idle,start=%b need 110", {ap_done, ap_idle, ap_start});
        end
        for (int c = 0; c < 5; c++) begin @(negedge clk); if (data_we || cfg_lock) we_seen++; end
        total++;
        if (we_seen != 0) begin bad++; $display("FAIL len0 no init: busy cycles=%0d need 0", we_seen); end
        @(negedge clk);
        cfg_done_clr = 1'b1; cfg_start = 1'b1; cfg_len = 0;
        @(posedge clk); #1;
        cfg_done_clr = 1'b0; cfg_start = 1'b0;
        total++;
        if (ap_done !== 1'b1) begin bad++; $display("FAIL set beats clr: done=%b need 1", ap_done); end
    endtask

    task automatic test_tlast_err();
        bit ok, l;
        int y;
        rand_taps(); rand_x(3);
        do_start(3);
        send_x(xq[0], 1, ok);
        total++;
        if (err_tlast !== 1'b1) begin bad++; $display("FAIL early tlast: err=%b need 1", err_tlast); end
        recv_y(0, y, l, ok);
        for (int i = 1; i < 3; i++) begin
            send_x(xq[i], i == 2, ok);
            recv_y(0, y, l, ok);
        end
        total++;
        if ({err_tlast, ap_done} !== 2'b11) begin bad++; $display("FAIL err sticky: err,done=%b need 11", {err_tlast, ap_done}); end
        rand_x(2);
        yq.delete(); lq.delete();
        do_start(2);
        total++;
        if ({err_tlast, ap_done, ap_start} !== 3'b001) begin
            bad++; $display("FAIL restart clears: err,done,start=%b need 001", {err_tlast, ap_done, ap_start});
        end
        run_samples(0, 1, ok);
        check_block("after-err", ok);
        total++;
        if (err_tlast !== 1'b0) begin bad++; $display("FAIL clean tlast: err=%b need 0", err_tlast); end
    endtask

    initial begin
        test_reset();
        test_init_impulse();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_done_len0();
        test_tlast_err();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
